morse_receiver: RTL and testbench

//  Converts a raw straight-key input into Morse characters and feeds the seven-segment

---
 rtl/morse_receiver.sv | 135 +++++++++++++
 tb/tb_morse_receiver.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/morse_receiver.sv
// morse_receiver: synchronises and debounces a straight key, times marks and spaces in
// Morse units and emits one pulse per decoded character (or word space).
module morse_receiver #(
    parameter int UNIT_CYCLES     = 10_000_000,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int DASH_UNITS      = 2,
    parameter int CHAR_GAP_UNITS  = 2,
    parameter int WORD_GAP_UNITS  = 5
) (
    input  logic       clk_100Mhz,
    input  logic       reset_n,
    input  logic       key_in,
    output logic       data_valid,
    output logic [2:0] char_index,
    output logic [5:0] char_data,
    output logic       key_db,
    output logic       char_err
);
    localparam int CW = $clog2(UNIT_CYCLES);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, MARK, CGAP, WGAP} state_t;

    state_t        state_q;
    logic [1:0]    sync_q;
    logic [DW-1:0] db_cnt_q;
    logic          key_db_q;
    logic [CW-1:0] cyc_q;
    logic [3:0]    unit_q;
    logic [2:0]    cnt_q;
    logic [5:0]    bits_q;
    logic          ovf_q;
    logic          emitted_q;
    logic          dv_q;
    logic          err_q;
    logic [2:0]    idx_q;
    logic [5:0]    dat_q;

    logic       key_sync;
    logic       flip;
    logic       rise;
    logic       fall;
    logic       tick;
    logic       dash;
    logic       reach_c;
    logic       reach_w;
    logic [3:0] unit_d;

    // unit_d includes the cycle in progress, so a mark of exactly DASH_UNITS units is a dash
    always_comb begin
        key_sync = sync_q[1];
        flip     = (key_sync != key_db_q) && (db_cnt_q == DW'(DEBOUNCE_CYCLES - 1));
        rise     = flip && !key_db_q;
        fall     = flip && key_db_q;
        tick     = cyc_q == CW'(UNIT_CYCLES - 1);
        unit_d   = (tick && unit_q != 4'd15) ? unit_q + 4'd1 : unit_q;
        dash     = unit_d >= 4'(DASH_UNITS);
        reach_c  = tick && (unit_q == 4'(CHAR_GAP_UNITS - 1));
        reach_w  = tick && (unit_q == 4'(WORD_GAP_UNITS - 1));
    end

    always_ff @(posedge clk_100Mhz or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            sync_q    <= '0;
            db_cnt_q  <= '0;
            key_db_q  <= 1'b0;
            cyc_q     <= '0;
            unit_q    <= '0;
            cnt_q     <= '0;
            bits_q    <= '0;
            ovf_q     <= 1'b0;
            emitted_q <= 1'b0;
            dv_q      <= 1'b0;
            err_q     <= 1'b0;
            idx_q     <= '0;
            dat_q     <= '0;
        end else begin
            sync_q   <= {sync_q[0], key_in};
            db_cnt_q <= (key_sync == key_db_q || flip) ? '0 : db_cnt_q + DW'(1);
            key_db_q <= flip ? key_sync : key_db_q;
            cyc_q    <= (flip || tick) ? '0 : cyc_q + CW'(1);
            unit_q   <= flip ? 4'd0 : unit_d;
            dv_q     <= 1'b0;
            err_q    <= 1'b0;
            case (state_q)
                IDLE: if (rise) begin
                    state_q <= MARK;
                    cnt_q   <= '0;
                    bits_q  <= '0;
                    ovf_q   <= 1'b0;
                end
                MARK: if (fall) begin
                    state_q <= CGAP;
                    if (cnt_q == 3'd5) ovf_q <= 1'b1;
                    else begin
                        bits_q <= {bits_q[4:0], dash};
                        cnt_q  <= cnt_q + 3'd1;
                    end
                end
                CGAP: if (rise) state_q <= MARK;
                else if (reach_c) begin
                    state_q <= WGAP;
                    if (ovf_q) err_q <= 1'b1;
                    else begin
                        dv_q      <= 1'b1;
                        idx_q     <= cnt_q - 3'd1;
                        dat_q     <= bits_q;
                        emitted_q <= 1'b1;
                    end
                end
                WGAP: if (rise) begin
                    state_q <= MARK;
                    cnt_q   <= '0;
                    bits_q  <= '0;
                    ovf_q   <= 1'b0;
                end else if (reach_w) begin
                    state_q <= IDLE;
                    if (emitted_q) begin
                        dv_q      <= 1'b1;
                        idx_q     <= 3'd5;
                        dat_q     <= '0;
                        emitted_q <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign data_valid = dv_q;
    assign char_err   = err_q;
    assign char_index = idx_q;
    assign char_data  = dat_q;
    assign key_db     = key_db_q;
endmodule

// File: tb/tb_morse_receiver.sv
// tb_morse_receiver: drives timed key patterns and checks every output pulse (kind, payload,
// arrival cycle) against a symbol-level Morse model.
module tb_morse_receiver;
    localparam int U   = 10;
    localparam int DB  = 4;
    localparam int LAT = 6;

    typedef struct packed {
        logic [1:0]  kind;
        logic [2:0]  idx;
        logic [5:0]  data;
        logic [31:0] at;
    } ev_t;

    logic       clk_100Mhz = 1'b0;
    logic       reset_n    = 1'b0;
    logic       key_in     = 1'b0;
    logic       data_valid;
    logic [2:0] char_index;
    logic [5:0] char_data;
    logic       key_db;
    logic       char_err;

    int unsigned now = 0;
    int          vectors = 0;
    int          miscompares = 0;
    ev_t         obs_q[$];
    ev_t         exp_q[$];
    int          m_n;
    int          m_code;
    bit          m_ovf;
    bit          m_emit;
    logic [8:0]  m_last;

    always #5 clk_100Mhz = ~clk_100Mhz;

    morse_receiver #(.UNIT_CYCLES(U), .DEBOUNCE_CYCLES(DB)) dut (
        .clk_100Mhz(clk_100Mhz),
        .reset_n(reset_n),
        .key_in(key_in),
        .data_valid(data_valid),
        .char_index(char_index),
        .char_data(char_data),
        .key_db(key_db),
        .char_err(char_err)
    );

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_100Mhz);
            now++;
            if (data_valid || char_err)
                obs_q.push_back(ev_t'{{data_valid, char_err}, char_index, char_data, now});
        end
    endtask

    task automatic model_reset();
        m_n = 0;
        m_code = 0;
        m_ovf = 0;
        m_emit = 0;
        m_last = '0;
    endtask

    // One mark then one space; optional low glitch inside the mark. The model then predicts pulses.
    task automatic send(input int mark, input int gap, input int g_at = 0, input int g_len = 0);
        int unsigned rel;
        key_in = 1'b1;
        if (g_len > 0) begin
            step(g_at);
            key_in = 1'b0;
            step(g_len);
            key_in = 1'b1;
            step(mark - g_at - g_len);
        end else step(mark);
        key_in = 1'b0;
        rel = now;
        step(gap);
        if (m_n < 5) begin
            m_code = m_code * 2 + ((mark >= 2 * U) ? 1 : 0);
            m_n++;
        end else m_ovf = 1;
        if (gap > 2 * U) begin
            if (m_ovf) exp_q.push_back(ev_t'{2'b01, m_last[8:6], m_last[5:0], 32'(rel + LAT + 2 * U)});
            else begin
                m_last = {3'(m_n - 1), 6'(m_code)};
                exp_q.push_back(ev_t'{2'b10, m_last[8:6], m_last[5:0], 32'(rel + LAT + 2 * U)});
                m_emit = 1;
            end
            m_n = 0;
            m_code = 0;
            m_ovf = 0;
            if (gap > 5 * U && m_emit) begin
                m_last = {3'd5, 6'd0};
                exp_q.push_back(ev_t'{2'b10, 3'd5, 6'd0, 32'(rel + LAT + 5 * U)});
                m_emit = 0;
            end
        end
    endtask

    task automatic test_reset();
        step(3);
        vectors++;
        if ({data_valid, char_index, char_data, key_db, char_err} !== 12'd0) begin
            miscompares++;
            $display("FAIL reset_hold got %b exp 0", {data_valid, char_index, char_data, key_db, char_err});
        end
        reset_n = 1'b1;
        step(8);
        vectors++;
        if ({data_valid, char_index, char_data, key_db, char_err} !== 12'd0) begin
            miscompares++;
            $display("FAIL reset_release got %b exp 0", {data_valid, char_index, char_data, key_db, char_err});
        end
        model_reset();
    endtask

    task automatic test_letters();
        obs_q.delete();
        exp_q.delete();
        send(10, 70);
        send(10, 10);
        send(30, 70);
        send(30, 10);
        send(10, 70);
        vectors++;
        if (obs_q.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL letters_count got %0d exp %0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            ev_t o = (i < obs_q.size()) ? obs_q[i] : '0;
            vectors++;
            if (o !== exp_q[i]) begin
                miscompares++;
                $display("FAIL letters_ev%0d got %h exp %h", i, o, exp_q[i]);
            end
        end
    endtask

    task automatic test_word_space();
        obs_q.delete();
        exp_q.delete();
        send(30, 200);
        vectors++;
        if (obs_q.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL space_count got %0d exp %0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            ev_t o = (i < obs_q.size()) ? obs_q[i] : '0;
            vectors++;
            if (o !== exp_q[i]) begin
                miscompares++;
                $display("FAIL space_ev%0d got %h exp %h", i, o, exp_q[i]);
            end
        end
    endtask

    task automatic test_overflow();
        obs_q.delete();
        exp_q.delete();
        for (int s = 0; s < 5; s++) send(10, 10);
        send(10, 120);
        vectors++;
        if (obs_q.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL ovf_count got %0d exp %0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            ev_t o = (i < obs_q.size()) ? obs_q[i] : '0;
            vectors++;
            if (o !== exp_q[i]) begin
                miscompares++;
                $display("FAIL ovf_ev%0d got %h exp %h", i, o, exp_q[i]);
            end
        end
    endtask

    task automatic test_glitch();
        obs_q.delete();
        exp_q.delete();
        for (int g = 1; g <= 3; g++) begin
            key_in = 1'b1;
            step(g);
            key_in = 1'b0;
            for (int k = 0; k < 10; k++) begin
                step(1);
                vectors++;
                if (key_db !== 1'b0) begin
                    miscompares++;
                    $display("FAIL glitch_idle_keydb len %0d got %b exp 0", g, key_db);
                end
            end
        end
        send(15, 10, 6, 3);
        send(30, 70, 10, 2);
        send(25, 70, 8, 1);
        vectors++;
        if (obs_q.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL glitch_count got %0d exp %0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            ev_t o = (i < obs_q.size()) ? obs_q[i] : '0;
            vectors++;
            if (o !== exp_q[i]) begin
                miscompares++;
                $display("FAIL glitch_ev%0d got %h exp %h", i, o, exp_q[i]);
            end
        end
    endtask

    task automatic test_boundary();
        obs_q.delete();
        exp_q.delete();
        send(19, 10);
        send(20, 20);
        send(170, 21);
        send(12, 70);
        vectors++;
        if (obs_q.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL bound_count got %0d exp %0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            ev_t o = (i < obs_q.size()) ? obs_q[i] : '0;
            vectors++;
            if (o !== exp_q[i]) begin
                miscompares++;
                $display("FAIL bound_ev%0d got %h exp %h", i, o, exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        obs_q.delete();
        exp_q.delete();
        key_in = 1'b1;
        step(15);
        #2 reset_n = 1'b0;
        #1;
        vectors++;
        if ({data_valid, char_index, char_data, key_db, char_err} !== 12'd0) begin
            miscompares++;
            $display("FAIL rst_mark got %b exp 0", {data_valid, char_index, char_data, key_db, char_err});
        end
        key_in = 1'b0;
        step(3);
        reset_n = 1'b1;
        step(80);
        key_in = 1'b1;
        step(12);
        key_in = 1'b0;
        step(12);
        #2 reset_n = 1'b0;
        #1;
        vectors++;
        if ({data_valid, char_index, char_data, key_db, char_err} !== 12'd0) begin
            miscompares++;
            $display("FAIL rst_cgap got %b exp 0", {data_valid, char_index, char_data, key_db, char_err});
        end
        step(3);
        reset_n = 1'b1;
        step(80);
        model_reset();
        send(10, 70);
        vectors++;
        if (obs_q.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL rst_count got %0d exp %0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            ev_t o = (i < obs_q.size()) ? obs_q[i] : '0;
            vectors++;
            if (o !== exp_q[i]) begin
                miscompares++;
                $display("FAIL rst_ev%0d got %h exp %h", i, o, exp_q[i]);
            end
        end
    endtask

    task automatic test_random();
        obs_q.delete();
        exp_q.delete();
        for (int c = 0; c < 25; c++) begin
            int nsym = ($urandom_range(0, 9) == 0) ? 6 : int'($urandom_range(1, 5));
            for (int s = 0; s < nsym; s++) begin
                int mark = $urandom_range(0, 1) ? int'($urandom_range(20, 40)) : int'($urandom_range(5, 18));
                int gap = (s < nsym - 1) ? int'($urandom_range(8, 18)) :
                          ($urandom_range(0, 2) == 0) ? int'($urandom_range(55, 80)) : int'($urandom_range(22, 45));
                send(mark, gap);
            end
        end
        send(10, 70);
        vectors++;
        if (obs_q.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL rand_count got %0d exp %0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            ev_t o = (i < obs_q.size()) ? obs_q[i] : '0;
            vectors++;
            if (o !== exp_q[i]) begin
                miscompares++;
                $display("FAIL rand_ev%0d got %h exp %h", i, o, exp_q[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_letters();
        test_word_space();
        test_overflow();
        test_glitch();
        test_boundary();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
